// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the bit serializer and the serial sequence detector
// it feeds.
//   ser_state_e   : serializer FSM encoding (IDLE / SHIFT / PARITY)
//   SER_WIDTH_DEF : default parallel word width
//   DET_PATTERN   : bit pattern the downstream detector looks for (MSB is the
//                   oldest bit), so benches can chain the two blocks
// ---------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } ser_state_e;

    localparam int SER_WIDTH_DEF = 8;

    localparam int                       DET_PATTERN_W = 4;
    localparam logic [DET_PATTERN_W-1:0] DET_PATTERN   = 4'b1011;

endpackage

// File: rtl/piso_bit_serializer.sv
// ---------------------------------------------------------------------------
// piso_bit_serializer
// Parallel-in / serial-out stage feeding the serial sequence detector.
// Words arrive on a valid/ready handshake and leave MSB-first, one bit per
// clock. A one-word holding buffer lets the next word be accepted while the
// current one is shifting, so consecutive words stream with no gap.
//
// Optional build macro: SER_PARITY_EN
//   defined   : each word is followed by one even-parity bit (period WIDTH+1)
//   undefined : data bits only (period WIDTH)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   din        in   WIDTH-bit parallel word
//   din_valid  in   din holds a valid word
//   din_ready  out  a word can be accepted this cycle (holding buffer empty)
//   ser_out    out  serial bit (0 whenever ser_valid is 0)
//   ser_valid  out  ser_out carries a real bit
//   word_done  out  pulse in the last serial cycle of each word
//   busy       out  shifting, emitting parity, or holding a word
// ---------------------------------------------------------------------------
module piso_bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    ser_state_e       state, state_n;
    logic [WIDTH-1:0] shift_reg, shift_n;
    logic [WIDTH-1:0] hold_reg, hold_n;
    logic [CNT_W-1:0] bit_cnt, cnt_n;
    logic             hold_full, hold_full_n;
    logic             accept;
    logic             word_end;
    logic             load;
    logic [WIDTH-1:0] load_word;
    logic             ser_out_n;
    logic             word_done_n;
`ifdef SER_PARITY_EN
    logic             par_reg, par_n;
`endif

    assign din_ready = !hold_full;
    assign accept    = din_valid && din_ready;
    assign busy      = (state != IDLE) || hold_full;

    // Edge at which the current word finishes and the next one is chosen.
`ifdef SER_PARITY_EN
    assign word_end = (state == PARITY);
`else
    assign word_end = (state == SHIFT) && (bit_cnt == '0);
`endif

    always_comb begin
        state_n     = state;
        shift_n     = shift_reg;
        cnt_n       = bit_cnt;
        hold_n      = hold_reg;
        hold_full_n = hold_full;
        load        = 1'b0;
        load_word   = din;
`ifdef SER_PARITY_EN
        par_n       = par_reg;
`endif

        case (state)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                shift_n = {shift_reg[WIDTH-2:0], 1'b0};
                cnt_n   = bit_cnt - CNT_W'(1);
`ifdef SER_PARITY_EN
                if (bit_cnt == '0) begin
                    state_n = PARITY;
                end
`endif
                // A word offered mid-stream parks in the holding buffer;
                // accept already implies the buffer is empty.
                if (accept && !word_end) begin
                    hold_n      = din;
                    hold_full_n = 1'b1;
                end
            end
            default: begin
`ifndef SER_PARITY_EN
                state_n = IDLE;
`endif
            end
        endcase

        // Held word has priority; a held word and a fresh accept never
        // coincide because din_ready is low while the buffer is full.
        if (word_end) begin
            if (hold_full) begin
                load        = 1'b1;
                load_word   = hold_reg;
                hold_full_n = 1'b0;
            end else if (accept) begin
                load = 1'b1;
            end else begin
                state_n = IDLE;
            end
        end

        if (load) begin
            state_n = SHIFT;
            shift_n = load_word;
            cnt_n   = LAST_IDX;
`ifdef SER_PARITY_EN
            par_n   = ^load_word;
`endif
        end

        // Outputs are registered, so they are derived from the next state.
        case (state_n)
            SHIFT:   ser_out_n = shift_n[WIDTH-1];
`ifdef SER_PARITY_EN
            PARITY:  ser_out_n = par_n;
`endif
            default: ser_out_n = 1'b0;
        endcase

`ifdef SER_PARITY_EN
        word_done_n = (state_n == PARITY);
`else
        word_done_n = (state_n == SHIFT) && (cnt_n == '0);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            word_done <= 1'b0;
`ifdef SER_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_cnt   <= cnt_n;
            hold_reg  <= hold_n;
            hold_full <= hold_full_n;
            ser_out   <= ser_out_n;
            ser_valid <= (state_n != IDLE);
            word_done <= word_done_n;
`ifdef SER_PARITY_EN
            par_reg   <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_bit_serializer
// Directed bench for piso_bit_serializer (WIDTH = 8). Inputs change on the
// falling edge; outputs are sampled on the falling edge. Expected bit streams
// are hand-computed constants, selected by SER_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_piso_bit_serializer;
    import ser_pkg::*;

`ifdef SER_PARITY_EN
    localparam int          PER     = 9;
    localparam int          T1_N    = 9;
    localparam logic [31:0] T1_BITS = 32'h0000_016D;
    localparam logic [31:0] T1_DONE = 32'h0000_0100;
    localparam logic [31:0] T1_RDY  = 32'h0000_01FF;
    localparam int          T2_N    = 18;
    localparam logic [31:0] T2_BITS = 32'h0003_6CDB;
    localparam logic [31:0] T2_DONE = 32'h0002_0100;
    localparam logic [31:0] T2_RDY  = 32'h0003_FE01;
    localparam logic [31:0] T6_BITS = 32'h0000_000F;
    localparam logic [31:0] T6_DONE = 32'h0000_0100;
`else
    localparam int          PER     = 8;
    localparam int          T1_N    = 8;
    localparam logic [31:0] T1_BITS = 32'h0000_00B6;
    localparam logic [31:0] T1_DONE = 32'h0000_0080;
    localparam logic [31:0] T1_RDY  = 32'h0000_00FF;
    localparam int          T2_N    = 16;
    localparam logic [31:0] T2_BITS = 32'h0000_DB6D;
    localparam logic [31:0] T2_DONE = 32'h0000_8080;
    localparam logic [31:0] T2_RDY  = 32'h0000_FF01;
    localparam logic [31:0] T6_BITS = 32'h0000_0007;
    localparam logic [31:0] T6_DONE = 32'h0000_0080;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       word_done;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    piso_bit_serializer #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .word_done (word_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Checks n consecutive serial cycles starting with the current one.
    // bits holds the stream MSB-first in its low n bits; done_m/rdy_m give
    // word_done/din_ready per cycle (bit i = cycle i). din_valid is dropped
    // after the checks of cycle drop_at.
    task automatic serial_check(input string tag, input logic [31:0] bits, input int n,
                                input logic [31:0] done_m, input logic [31:0] rdy_m,
                                input int drop_at);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_vld%0d", tag, i), {31'b0, ser_valid}, 32'd1);
            chk($sformatf("%s_bit%0d", tag, i), {31'b0, ser_out}, {31'b0, bits[n-1-i]});
            chk($sformatf("%s_done%0d", tag, i), {31'b0, word_done}, {31'b0, done_m[i]});
            chk($sformatf("%s_rdy%0d", tag, i), {31'b0, din_ready}, {31'b0, rdy_m[i]});
            if (i == drop_at) din_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DET_PATTERN_W-1:0] win;
        logic [7:0]               got;
        logic [7:0]               w;
        int                       hits;
        int                       nb;
        int                       j;
        int                       guard;
        logic                     e;

        reset     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, ser_valid}, 32'd0);
        chk("rst_out",   {31'b0, ser_out},   32'd0);
        chk("rst_done",  {31'b0, word_done}, 32'd0);
        chk("rst_ready", {31'b0, din_ready}, 32'd1);
        chk("rst_busy",  {31'b0, busy},      32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 1: single word 8'hB6
        din = 8'hB6; din_valid = 1'b1;
        @(negedge clk);
        serial_check("t1", T1_BITS, T1_N, T1_DONE, T1_RDY, 0);
        chk("t1_idle_vld",  {31'b0, ser_valid}, 32'd0);
        chk("t1_idle_out",  {31'b0, ser_out},   32'd0);
        chk("t1_idle_busy", {31'b0, busy},      32'd0);
        @(negedge clk);

        // 2: back-to-back 8'hDB then 8'h6D through the holding buffer
        din = 8'hDB; din_valid = 1'b1;
        @(negedge clk);
        din = 8'h6D;
        serial_check("t2", T2_BITS, T2_N, T2_DONE, T2_RDY, 1);
        chk("t2_idle_vld", {31'b0, ser_valid}, 32'd0);
        @(negedge clk);

        // 3: detector pattern occurrences (overlapping) in the 8'hDB stream
        din = 8'hDB; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        win = '0; got = '0; hits = 0; nb = 0;
        for (int i = 0; i < PER; i++) begin
            if (ser_valid) begin
                win = {win[DET_PATTERN_W-2:0], ser_out};
                nb++;
                if (nb >= DET_PATTERN_W && win == DET_PATTERN) hits++;
            end
            if (i < 8) got = {got[6:0], ser_out};
            @(negedge clk);
        end
        chk("t3_hits", hits, 32'd2);
        chk("t3_word", {24'b0, got}, 32'h0000_00DB);
        @(negedge clk);

        // 4: asynchronous reset during the 4th bit of 8'hF0 with 8'hAA held
        din = 8'hF0; din_valid = 1'b1;
        @(negedge clk);
        din = 8'hAA;
        @(negedge clk);
        din_valid = 1'b0;
        chk("t4_held_rdy",  {31'b0, din_ready}, 32'd0);
        chk("t4_held_busy", {31'b0, busy},      32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t4_bit3_vld", {31'b0, ser_valid}, 32'd1);
        chk("t4_bit3_out", {31'b0, ser_out},   32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t4_async_vld",  {31'b0, ser_valid}, 32'd0);
        chk("t4_async_out",  {31'b0, ser_out},   32'd0);
        chk("t4_async_done", {31'b0, word_done}, 32'd0);
        chk("t4_async_busy", {31'b0, busy},      32'd0);
        chk("t4_async_rdy",  {31'b0, din_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("t4_post_vld%0d", i), {31'b0, ser_valid}, 32'd0);
            chk($sformatf("t4_post_busy%0d", i), {31'b0, busy}, 32'd0);
        end
        chk("t4_post_rdy", {31'b0, din_ready}, 32'd1);

        // 5: din_valid held high with incrementing data
        din = 8'h10; din_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (i == 0 || ((i - 1) % PER) == 0) din = din + 8'd1;
            w = 8'h10 + 8'(i / PER);
            j = i % PER;
            e = (j < 8) ? w[7-j] : ^w;
            chk($sformatf("t5_vld%0d", i), {31'b0, ser_valid}, 32'd1);
            chk($sformatf("t5_bit%0d", i), {31'b0, ser_out}, {31'b0, e});
            chk($sformatf("t5_rdy%0d", i), {31'b0, din_ready}, (j == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        din_valid = 1'b0;
        guard = 0;
        while (busy && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk("t5_drain", {31'b0, busy}, 32'd0);
        @(negedge clk);

        // 6: 8'h07 -- parity bit position / word_done placement
        din = 8'h07; din_valid = 1'b1;
        @(negedge clk);
        serial_check("t6", T6_BITS, PER, T6_DONE, 32'h0000_01FF, 0);
        chk("t6_idle_vld", {31'b0, ser_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the serial sequence detector; drives the detector's 1-bit `in` stream.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock.
- A one-word holding buffer gives gapless back-to-back streaming, so overlapping patterns that span word boundaries reach the detector intact.

Parameters:
WIDTH  8  data word width in bits; legal range 2..32
CNT_W  $clog2(WIDTH)  bit-index counter width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a valid word
din_ready  output  1  block can accept a word this cycle (= !hold_full)
ser_out  output  1  serial bit, feeds detector `in`
ser_valid  output  1  ser_out carries a real bit this cycle
word_done  output  1  one-cycle pulse on the last serial cycle of each word
busy  output  1  state != IDLE or hold_full

Behaviour:
- Reset (reset=0, async): state=IDLE, shift_reg=0, bit_cnt=0, hold_reg=0, hold_full=0, ser_out=0, ser_valid=0, word_done=0. din_ready reads 1, but all writes are blocked while reset=0. Reset mid-word drops the word in flight and any held word; no partial bits are resumed.
- Accept: a word transfers on a rising edge when din_valid && din_ready.
- FSM states: IDLE, SHIFT (plus PARITY, see optional feature).
- IDLE:
  - On accept, din loads directly into shift_reg, bit_cnt=WIDTH-1, next state SHIFT.
  - The first bit (din[WIDTH-1]) appears on ser_out with ser_valid=1 in the cycle after the accepting edge. Latency = 1 cycle.
- SHIFT:
  - ser_out = shift_reg[WIDTH-1], ser_valid=1.
  - Each edge shifts left by one and decrements bit_cnt.
  - On the last bit (bit_cnt==0), word_done=1.
- Next-word selection at the last-bit edge:
  - hold_full: hold_reg -> shift_reg, hold_full=0, stay SHIFT.
  - Else if accept occurs at that edge: din -> shift_reg, stay SHIFT.
  - Else: go to IDLE.
  - Result: no idle cycle between words.
- Accept during SHIFT at a non-last bit: din -> hold_reg, hold_full=1. din_ready then drops until the held word is consumed.
- Simultaneous hold drain and accept at the last-bit edge: cannot occur, because din_ready=0 while hold_full=1.
- ser_out=0 whenever ser_valid=0.
- ser_out, ser_valid and word_done are registered outputs. din_ready is combinational from hold_full only.
- Throughput: one word per WIDTH cycles sustained. Maximum two words buffered (shift + hold).

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PARITY for one cycle.
  - ser_out = even parity (XOR of all WIDTH data bits, computed at load), ser_valid=1.
  - word_done pulses in the PARITY cycle, not on the last data bit.
  - Next-word selection moves to the PARITY edge.
  - Word period = WIDTH+1 cycles.
- Undefined: no PARITY state, no parity register; word period = WIDTH cycles.

Decomposition:
- Shared package `ser_pkg` holds:
  - state encoding localparams: IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10;
  - default WIDTH;
  - the detector pattern constant, so benches can chain the serializer and detector.
- No sub-module needed. Optionally factor out `ser_hold_buf` (one-entry valid/ready register) if reused elsewhere.

Test Plan:
1. Reset held 2 cycles, then din=8'hB6 with din_valid pulsed 1 cycle -> from the next cycle, ser_out=1,0,1,1,0,1,1,0 with ser_valid=1 for 8 cycles; word_done on the 8th; then IDLE, ser_valid=0.
2. din=8'hDB accepted, then 8'h6D presented immediately -> 8'h6D is held (din_ready=0 for 7 cycles); 16 consecutive valid bits 11011011_01101101 with no gap; word_done at cycles 8 and 16.
3. Chain to the detector: stream 8'hDB -> detector output asserts on every overlapping pattern occurrence, and the counts match a golden model.
4. reset driven low during the 4th bit of 8'hF0 with a word held -> outputs zero immediately (async); after release, state IDLE, din_ready=1, no residual bits emitted.
5. din_valid held high continuously with an incrementing din -> exactly one accept per 8 cycles after the first; ser_valid never drops.
6. SER_PARITY_EN defined, din=8'h07 -> 8 data bits 00000111, then a parity bit of 1 in cycle 9 with word_done; without the macro, word_done falls in cycle 8.
